race_controller: RTL and testbench

//  Game-flow FSM for the two-player racer. Owns the 3-bit state bus that feeds OperationEncoder and both

---
 rtl/race_pkg.sv | 19 +
 rtl/race_tick_gen.sv | 55 +++++
 rtl/race_controller.sv | 192 +++++++++++++++++++
 tb/tb_race_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - shared game-flow state encodings, winner codes and race-time limit
package race_pkg;

    // 3-bit game state bus, also consumed by OperationEncoder and PhysicsEngine
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] COUNTDOWN = 3'd2;
    localparam logic [2:0] RACING    = 3'd4;
    localparam logic [2:0] PAUSED    = 3'd5;
    localparam logic [2:0] FINISH    = 3'd6;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_P1    = 2'b01;
    localparam logic [1:0] WIN_P2    = 2'b10;
    localparam logic [1:0] WIN_TIE   = 2'b11;

    // race timer saturates at four decimal digits of deciseconds
    localparam logic [13:0] DS_MAX   = 14'd9999;

endpackage

// File: rtl/race_tick_gen.sv
// rtl/race_tick_gen.sv - decisecond prescaler plus decade counter for second ticks
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   clr_i          zero both counters (wins over en_i)
//   en_i           advance counters; when low the counters hold their value
//   ds_tick_o      one-cycle pulse every DIV enabled cycles
//   s_tick_o       one-cycle pulse on every 10th ds_tick_o
module race_tick_gen #(
    parameter int unsigned DIV = 10
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic ds_tick_o,
    output logic s_tick_o
);

    localparam int unsigned    PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic [3:0]    dec_q, dec_d;

    // ticks do not look at clr_i: the controller derives clr_i from a tick
    assign ds_tick_o = en_i && (pre_q == PRE_LAST);
    assign s_tick_o  = ds_tick_o && (dec_q == 4'd9);

    always_comb begin
        pre_d = pre_q;
        dec_d = dec_q;
        if (clr_i) begin
            pre_d = '0;
            dec_d = '0;
        end else if (en_i) begin
            if (ds_tick_o) begin
                pre_d = '0;
                dec_d = (dec_q == 4'd9) ? 4'd0 : dec_q + 4'd1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pre_q <= '0;
            dec_q <= '0;
        end else begin
            pre_q <= pre_d;
            dec_q <= dec_d;
        end
    end

endmodule

// File: rtl/race_controller.sv
// rtl/race_controller.sv - game-flow FSM: countdown, race timer, checkpoint-gated laps, pause, winner
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   start_key_i, pause_key_i   key levels; acted on at their rising edge only
//   p1_line_i, p1_cp_i         P1 on start/finish line tiles, on checkpoint tiles (levels)
//   p2_line_i, p2_cp_i         same for P2
//   state_o                    game state (race_pkg encodings)
//   countdown_o                seconds left in COUNTDOWN, else 0
//   race_ds_o                  race time in deciseconds, saturating at DS_MAX
//   p1_laps_o, p2_laps_o       completed laps
//   winner_o                   none / P1 / P2 / tie
module race_controller
    import race_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned LAPS          = 3,
    parameter int unsigned COUNT_FROM    = 3,
    parameter int unsigned FINISH_HOLD_S = 5
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_key_i,
    input  logic        pause_key_i,
    input  logic        p1_line_i,
    input  logic        p1_cp_i,
    input  logic        p2_line_i,
    input  logic        p2_cp_i,
    output logic [2:0]  state_o,
    output logic [3:0]  countdown_o,
    output logic [13:0] race_ds_o,
    output logic [2:0]  p1_laps_o,
    output logic [2:0]  p2_laps_o,
    output logic [1:0]  winner_o
);

    localparam int unsigned       HOLD_W      = (FINISH_HOLD_S > 0) ? $clog2(FINISH_HOLD_S + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX    = HOLD_W'(FINISH_HOLD_S);
    localparam logic [2:0]        LAPS_WIN    = 3'(LAPS);
    localparam logic [3:0]        COUNT_START = 4'(COUNT_FROM);

    logic [2:0]        state_q, state_d;
    logic [3:0]        countdown_q, countdown_d;
    logic [13:0]       race_ds_q, race_ds_d;
    logic [1:0][2:0]   laps_q, laps_d, laps_inc;
    logic [1:0]        cp_q, cp_d;
    logic [1:0]        winner_q, winner_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [5:0]        key_prev_q;

    logic [5:0] key_now, key_rise;
    logic [1:0] line_e, cp_e, lap_hit, done;
    logic       start_e, pause_e, hold_done;
    logic       tick_clr, tick_en, ds_tick, s_tick;

    assign key_now  = {pause_key_i, start_key_i, p2_cp_i, p2_line_i, p1_cp_i, p1_line_i};
    assign key_rise = key_now & ~key_prev_q;
    assign line_e   = {key_rise[2], key_rise[0]};
    assign cp_e     = {key_rise[3], key_rise[1]};
    assign start_e  = key_rise[4];
    assign pause_e  = key_rise[5];
    assign hold_done = (hold_q == HOLD_MAX);

    // index 0 = P1, index 1 = P2; the lap test sees the flag before this cycle's cp edge
    for (genvar p = 0; p < 2; p++) begin : g_player
        assign lap_hit[p]  = line_e[p] & cp_q[p];
        assign laps_inc[p] = laps_q[p] + {2'b00, lap_hit[p]};
        assign done[p]     = lap_hit[p] && (laps_inc[p] == LAPS_WIN);
    end

    race_tick_gen #(
        .DIV (CLK_HZ / 10)
    ) u_tick (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (tick_clr),
        .en_i      (tick_en),
        .ds_tick_o (ds_tick),
        .s_tick_o  (s_tick)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (start_e) state_d = COUNTDOWN;
            COUNTDOWN: if (s_tick && countdown_q <= 4'd1) state_d = RACING;
            RACING: begin
                // a finishing lap outranks a simultaneous pause
                if (|done)        state_d = FINISH;
                else if (pause_e) state_d = PAUSED;
            end
            PAUSED:    if (pause_e) state_d = RACING;
            FINISH:    if (start_e && hold_done) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        tick_clr    = 1'b0;
        tick_en     = 1'b0;
        countdown_d = countdown_q;
        race_ds_d   = race_ds_q;
        laps_d      = laps_q;
        cp_d        = cp_q;
        winner_d    = winner_q;
        hold_d      = '0;
        case (state_q)
            IDLE: begin
                tick_clr = 1'b1;
                if (start_e) begin
                    countdown_d = COUNT_START;
                    race_ds_d   = '0;
                    laps_d      = '0;
                    cp_d        = '0;
                    winner_d    = WIN_NONE;
                end
            end
            COUNTDOWN: begin
                tick_en  = 1'b1;
                tick_clr = (state_d == RACING);
                if (s_tick) countdown_d = (countdown_q > 4'd1) ? countdown_q - 4'd1 : 4'd0;
            end
            RACING: begin
                tick_en = 1'b1;
                if (ds_tick && race_ds_q != DS_MAX) race_ds_d = race_ds_q + 14'd1;
                laps_d = laps_inc;
                cp_d   = cp_e | (cp_q & ~line_e);
                if (done == 2'b11)  winner_d = WIN_TIE;
                else if (done[0])   winner_d = WIN_P1;
                else if (done[1])   winner_d = WIN_P2;
            end
            PAUSED: begin
                // everything frozen; edges seen here are simply dropped
            end
            FINISH: begin
                tick_en = 1'b1;
                hold_d  = hold_q;
                if (s_tick && !hold_done) hold_d = hold_q + HOLD_W'(1);
                if (start_e && hold_done) begin
                    race_ds_d = '0;
                    laps_d    = '0;
                    cp_d      = '0;
                    winner_d  = WIN_NONE;
                    hold_d    = '0;
                end
            end
            default: begin
                tick_clr    = 1'b1;
                countdown_d = '0;
                race_ds_d   = '0;
                laps_d      = '0;
                cp_d        = '0;
                winner_d    = WIN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            countdown_q <= '0;
            race_ds_q   <= '0;
            laps_q      <= '0;
            cp_q        <= '0;
            winner_q    <= WIN_NONE;
            hold_q      <= '0;
            key_prev_q  <= '0;
        end else begin
            countdown_q <= countdown_d;
            race_ds_q   <= race_ds_d;
            laps_q      <= laps_d;
            cp_q        <= cp_d;
            winner_q    <= winner_d;
            hold_q      <= hold_d;
            key_prev_q  <= key_now;
        end
    end

    assign state_o     = state_q;
    assign countdown_o = countdown_q;
    assign race_ds_o   = race_ds_q;
    assign p1_laps_o   = laps_q[0];
    assign p2_laps_o   = laps_q[1];
    assign winner_o    = winner_q;

endmodule

// File: tb/tb_race_controller.sv
// tb/tb_race_controller.sv - self-checking bench for race_controller
module tb_race_controller;

    localparam int S_IDLE = 0;
    localparam int S_CD   = 2;
    localparam int S_RACE = 4;
    localparam int S_PAUS = 5;
    localparam int S_FIN  = 6;

    logic        clk;
    logic        rst_n;
    logic        start_key, pause_key, p1_line, p1_cp, p2_line, p2_cp;
    logic [2:0]  state;
    logic [3:0]  countdown;
    logic [13:0] race_ds;
    logic [2:0]  p1_laps, p2_laps;
    logic [1:0]  winner;

    logic [31:0] st_w, cd_w, ds_w, l1_w, l2_w, win_w;
    assign st_w  = 32'(state);
    assign cd_w  = 32'(countdown);
    assign ds_w  = 32'(race_ds);
    assign l1_w  = 32'(p1_laps);
    assign l2_w  = 32'(p2_laps);
    assign win_w = 32'(winner);

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // in bits: [0] p1_line [1] p1_cp [2] p2_line [3] p2_cp [4] pause
    typedef struct {
        int in;
        int st;
        int l1;
        int l2;
        int w;
    } vec_t;

    vec_t vecs[8];
    vec_t sb[$];

    race_controller #(
        .CLK_HZ        (100),
        .LAPS          (2),
        .COUNT_FROM    (3),
        .FINISH_HOLD_S (1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_key_i (start_key),
        .pause_key_i (pause_key),
        .p1_line_i   (p1_line),
        .p1_cp_i     (p1_cp),
        .p2_line_i   (p2_line),
        .p2_cp_i     (p2_cp),
        .state_o     (state),
        .countdown_o (countdown),
        .race_ds_o   (race_ds),
        .p1_laps_o   (p1_laps),
        .p2_laps_o   (p2_laps),
        .winner_o    (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic goto_cyc(input int target);
        while (cyc < target) step(1);
        if (cyc != target) begin
            n_err++;
            $display("FAIL schedule: at cycle %0d expected %0d", cyc, target);
        end
    endtask

    task automatic drive(input int v);
        p1_line   = v[0];
        p1_cp     = v[1];
        p2_line   = v[2];
        p2_cp     = v[3];
        pause_key = v[4];
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : test
        int s, r, f;
        vec_t e;

        vecs[0] = '{1,  S_RACE, 0, 0, 0};  // line without checkpoint
        vecs[1] = '{2,  S_RACE, 0, 0, 0};  // checkpoint
        vecs[2] = '{1,  S_RACE, 1, 0, 0};  // lap
        vecs[3] = '{1,  S_RACE, 1, 0, 0};  // flag consumed, no double count
        vecs[4] = '{12, S_RACE, 1, 0, 0};  // P2 cp+line together, flag was 0
        vecs[5] = '{4,  S_RACE, 1, 1, 0};  // P2 line, flag set by previous cp
        vecs[6] = '{2,  S_RACE, 1, 1, 0};
        vecs[7] = '{17, S_FIN,  2, 1, 1};  // finishing lap beats pause

        rst_n = 1'b0;
        start_key = 1'b0;
        drive(0);
        step(3);
        chk("rst_state", st_w, S_IDLE);
        chk("rst_countdown", cd_w, 0);
        chk("rst_race_ds", ds_w, 0);
        chk("rst_p1_laps", l1_w, 0);
        chk("rst_p2_laps", l2_w, 0);
        chk("rst_winner", win_w, 0);
        rst_n = 1'b1;
        step(2);

        // countdown with start held for 500 cycles
        start_key = 1'b1;
        step(1);
        s = cyc;
        chk("cd_enter_state", st_w, S_CD);
        chk("cd_enter_val", cd_w, 3);
        goto_cyc(s + 99);   chk("cd_3_end", cd_w, 3);
        goto_cyc(s + 100);  chk("cd_2", cd_w, 2);
        goto_cyc(s + 200);  chk("cd_1", cd_w, 1);
        goto_cyc(s + 299);  chk("cd_last_state", st_w, S_CD);
        goto_cyc(s + 300);  chk("race_start_state", st_w, S_RACE);
        chk("race_start_cd", cd_w, 0);
        r = s + 300;
        goto_cyc(s + 500);
        chk("held_start_state", st_w, S_RACE);
        chk("held_start_ds", ds_w, 20);
        start_key = 1'b0;

        // pause at race_ds 25
        goto_cyc(r + 255);
        pause_key = 1'b1;
        step(1);
        chk("pause_state", st_w, S_PAUS);
        chk("pause_ds", ds_w, 25);
        pause_key = 1'b0; step(1);
        p1_cp = 1'b1;     step(1);
        p1_cp = 1'b0;     step(1);
        p1_line = 1'b1;   step(1);
        p1_line = 1'b0;
        goto_cyc(r + 456);
        chk("paused_state", st_w, S_PAUS);
        chk("paused_ds", ds_w, 25);
        chk("paused_laps", l1_w, 0);
        pause_key = 1'b1;
        step(1);
        chk("resume_state", st_w, S_RACE);
        chk("resume_ds", ds_w, 25);
        pause_key = 1'b0;
        step(3);
        chk("resume_ds_hold", ds_w, 25);
        step(1);
        chk("resume_ds_tick", ds_w, 26);

        // lap table, scoreboard-ordered
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].in);
            sb.push_back(vecs[i]);
            step(1);
            e = sb.pop_front();
            chk($sformatf("vec%0d_state", i), st_w, e.st);
            chk($sformatf("vec%0d_p1", i), l1_w, e.l1);
            chk($sformatf("vec%0d_p2", i), l2_w, e.l2);
            chk($sformatf("vec%0d_winner", i), win_w, e.w);
            drive(0);
            step(1);
        end

        // race 1 finish: early start ignored, later start returns to IDLE
        start_key = 1'b1; step(1);
        chk("fin1_early_state", st_w, S_FIN);
        chk("fin1_laps_frozen", l1_w, 2);
        start_key = 1'b0; step(120);
        start_key = 1'b1; step(1);
        chk("fin1_exit_state", st_w, S_IDLE);
        chk("fin1_exit_ds", ds_w, 0);
        chk("fin1_exit_p1", l1_w, 0);
        chk("fin1_exit_winner", win_w, 0);

        // race 2: tie, finish aligned just after a second tick
        start_key = 1'b0; step(1);
        start_key = 1'b1; step(1);
        s = cyc;
        chk("r2_cd_state", st_w, S_CD);
        chk("r2_cd_val", cd_w, 3);
        start_key = 1'b0;
        r = s + 300;
        goto_cyc(r);
        chk("r2_race_state", st_w, S_RACE);
        chk("r2_race_ds", ds_w, 0);
        drive(10); step(1);
        drive(0);  step(1);
        drive(5);  step(1);
        chk("r2_lap1_p1", l1_w, 1);
        chk("r2_lap1_p2", l2_w, 1);
        drive(0);  step(1);
        drive(10); step(1);
        drive(0);  step(1);
        goto_cyc(r + 200);
        drive(5);
        step(1);
        f = cyc;
        chk("tie_state", st_w, S_FIN);
        chk("tie_winner", win_w, 3);
        chk("tie_p1", l1_w, 2);
        chk("tie_p2", l2_w, 2);
        chk("tie_ds", ds_w, 20);
        drive(0);
        goto_cyc(f + 49);
        start_key = 1'b1; step(1);
        chk("hold50_state", st_w, S_FIN);
        chk("hold50_ds", ds_w, 20);
        start_key = 1'b0;
        goto_cyc(f + 149);
        start_key = 1'b1; step(1);
        chk("hold150_state", st_w, S_IDLE);
        chk("hold150_ds", ds_w, 0);
        chk("hold150_winner", win_w, 0);
        chk("hold150_p2", l2_w, 0);

        // race 3: reset in the middle of racing
        start_key = 1'b0; step(1);
        start_key = 1'b1; step(1);
        s = cyc;
        start_key = 1'b0;
        goto_cyc(s + 330);
        chk("r3_state", st_w, S_RACE);
        chk("r3_ds", ds_w, 3);
        p1_cp = 1'b1;   step(1);
        p1_cp = 1'b0;   step(1);
        p1_line = 1'b1; step(1);
        chk("r3_p1_lap", l1_w, 1);
        p1_line = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_async_state", st_w, S_IDLE);
        step(1);
        rst_n = 1'b1;
        chk("mid_rst_state", st_w, S_IDLE);
        chk("mid_rst_ds", ds_w, 0);
        chk("mid_rst_p1", l1_w, 0);
        chk("mid_rst_winner", win_w, 0);
        step(2);
        chk("post_rst_state", st_w, S_IDLE);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
